// File: rtl/adc_avg_pkg.sv
// ============================================================================
// adc_avg_pkg : FSM state encoding and width helpers for the ADC averager.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package adc_avg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    ACQ  = 3'd3,
    OUT  = 3'd4
  } state_t;

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Sum of 2**al samples of dw signed bits always fits in dw+al signed bits.
  function automatic int acc_w(input int dw, input int al);
    return dw + al;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_avg_acc.sv
// ============================================================================
// adc_avg_acc : sample accumulator, sample counter and divide-by-shift.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module adc_avg_acc
  import adc_avg_pkg::*;
#(
  parameter int  DATA_W   = 12,
  parameter int  AVG_LOG2 = 3,
  localparam int ACC_W    = acc_w(DATA_W, AVG_LOG2)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic                     last_o,
  output logic signed [DATA_W-1:0] avg_o
);

  localparam logic [AVG_LOG2:0] LAST_CNT = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic        [AVG_LOG2:0] cnt_q;

  // The average is taken from the sum including the sample accepted this
  // cycle, so the result is ready on the same edge as the final sample.
  assign acc_d  = acc_q + ACC_W'(sample_i);
  assign avg_o  = DATA_W'(acc_d >>> AVG_LOG2);
  assign last_o = en_i && (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + (AVG_LOG2 + 1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_avg_mc.sv
// ============================================================================
// adc_avg_mc : round-robin multi-channel ADC burst averager (optional WAIT
// timeout enabled by macro ADC_TIMEOUT_EN).   Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module adc_avg_mc
  import adc_avg_pkg::*;
#(
  parameter int  DATA_W      = 12,
  parameter int  CH_NUM      = 4,
  parameter int  AVG_LOG2    = 3,
  parameter int  TIMEOUT_CYC = 32,
  localparam int CH_W        = ch_w(CH_NUM)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     syncro_i,
  output logic                     adc_data_req_o,
  output logic        [CH_W-1:0]   adc_ch_o,
  input  logic                     adc_data_rdy_i,
  input  logic signed [DATA_W-1:0] adc_data_i,
  output logic signed [DATA_W-1:0] data_o,
  output logic        [CH_W-1:0]   data_ch_o,
  output logic                     data_rdy_o,
  output logic                     err_o,
  output logic                     overrun_o,
  output logic                     busy_o
);

  if (CH_NUM < 2 || CH_NUM > 16 || AVG_LOG2 < 0 || AVG_LOG2 > 6 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("adc_avg_mc: parameter out of range");
  end

  state_t             state_q;
  logic [CH_W-1:0]    ch_q;
  logic [CH_W-1:0]    ch_d;
  logic [CH_W-1:0]    data_ch_q;
  logic [DATA_W-1:0]  data_q;
  logic               req_q;
  logic               data_rdy_q;
  logic               err_q;
  logic               overrun_q;
  logic               busy_q;
  logic               acc_clr;
  logic               acc_en;
  logic               acc_last;
  logic [DATA_W-1:0]  avg_next;

`ifdef ADC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  assign acc_clr = (state_q == IDLE);
  assign acc_en  = adc_data_rdy_i && ((state_q == WAIT) || (state_q == ACQ));
  assign ch_d    = (ch_q == CH_W'(CH_NUM - 1)) ? '0 : ch_q + CH_W'(1);

  adc_avg_acc #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (acc_clr),
    .en_i      (acc_en),
    .sample_i  (adc_data_i),
    .last_o    (acc_last),
    .avg_o     (avg_next)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      data_ch_q  <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      data_rdy_q <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ADC_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      req_q      <= 1'b0;
      data_rdy_q <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= syncro_i && (state_q != IDLE);
`ifdef ADC_TIMEOUT_EN
      tmo_q      <= (state_q == WAIT) ? tmo_q + TMO_W'(1) : '0;
`endif
      case (state_q)
        IDLE: begin
          if (syncro_i) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: state_q <= WAIT;
        WAIT: begin
          if (adc_data_rdy_i) begin
            if (acc_last) begin
              state_q    <= OUT;
              data_rdy_q <= 1'b1;
              data_q     <= avg_next;
              data_ch_q  <= ch_q;
            end else begin
              state_q <= ACQ;
            end
          end
`ifdef ADC_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
`endif
        end
        ACQ: begin
          // A gap in the burst aborts it; the channel is retried next trigger.
          if (!adc_data_rdy_i) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (acc_last) begin
            state_q    <= OUT;
            data_rdy_q <= 1'b1;
            data_q     <= avg_next;
            data_ch_q  <= ch_q;
          end
        end
        OUT: begin
          state_q <= IDLE;
          ch_q    <= ch_d;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_data_req_o = req_q;
  assign adc_ch_o       = ch_q;
  assign data_o         = data_q;
  assign data_ch_o      = data_ch_q;
  assign data_rdy_o     = data_rdy_q;
  assign err_o          = err_q;
  assign overrun_o      = overrun_q;
  assign busy_o         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_avg_mc.sv
// ============================================================================
// tb_adc_avg_mc : randomized scoreboard bench for adc_avg_mc.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_adc_avg_mc;

  localparam int DATA_W   = 12;
  localparam int CH_NUM   = 4;
  localparam int AVG_LOG2 = 3;
  localparam int CH_W     = 2;
  localparam int N        = 1 << AVG_LOG2;

  logic                     clk_i = 1'b0;
  logic                     reset_n_i = 1'b0;
  logic                     syncro_i = 1'b0;
  logic                     adc_data_req_o;
  logic        [CH_W-1:0]   adc_ch_o;
  logic                     adc_data_rdy_i = 1'b0;
  logic signed [DATA_W-1:0] adc_data_i = '0;
  logic signed [DATA_W-1:0] data_o;
  logic        [CH_W-1:0]   data_ch_o;
  logic                     data_rdy_o;
  logic                     err_o;
  logic                     overrun_o;
  logic                     busy_o;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int ovr_seen = 0;
  int exp_data[$];
  int exp_ch[$];
  int model_ch = 0;
  int last_data = 0;
  int smp[16];

  adc_avg_mc #(
    .DATA_W      (DATA_W),
    .CH_NUM      (CH_NUM),
    .AVG_LOG2    (AVG_LOG2),
    .TIMEOUT_CYC (32)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .syncro_i       (syncro_i),
    .adc_data_req_o (adc_data_req_o),
    .adc_ch_o       (adc_ch_o),
    .adc_data_rdy_i (adc_data_rdy_i),
    .adc_data_i     (adc_data_i),
    .data_o         (data_o),
    .data_ch_o      (data_ch_o),
    .data_rdy_o     (data_rdy_o),
    .err_o          (err_o),
    .overrun_o      (overrun_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mathematical mean rounded toward minus infinity.
  function automatic int floor_div(input int s, input int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_expected();
    int sum = 0;
    for (int i = 0; i < N; i++) sum += smp[i];
    last_data = floor_div(sum, N);
    exp_data.push_back(last_data);
    exp_ch.push_back(model_ch);
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_n_i) begin
        if (data_rdy_o) begin
          if (exp_data.size() == 0) begin
            chk("unexpected_data_rdy", 1, 0);
          end else begin
            chk("data_o", int'(data_o), exp_data.pop_front());
            chk("data_ch_o", int'(data_ch_o), exp_ch.pop_front());
          end
        end
        if (err_o) err_seen++;
        if (overrun_o) ovr_seen++;
      end
    end
  end

  task automatic trigger_to_wait();
    int k = 0;
    syncro_i = 1'b1;
    tick();
    syncro_i = 1'b0;
    while (!adc_data_req_o && k < 8) begin
      tick();
      k++;
    end
    chk("req_pulse", adc_data_req_o, 1);
    chk("req_channel", int'(adc_ch_o), model_ch);
    chk("busy_in_req", busy_o, 1);
    tick();
    chk("req_one_cycle", adc_data_req_o, 0);
  endtask

  task automatic burst(input int n, input bit trig_mid);
    int e0 = err_seen;
    int o0 = ovr_seen;
    tick();
    trigger_to_wait();
    repeat ($urandom_range(0, 3)) tick();
    if (n >= N) push_expected();
    for (int i = 0; i < n; i++) begin
      adc_data_rdy_i = 1'b1;
      adc_data_i     = DATA_W'(smp[i]);
      syncro_i       = trig_mid && (i == 2);
      tick();
      if (i == N - 1) chk("rdy_after_last_sample", data_rdy_o, 1);
    end
    adc_data_rdy_i = 1'b0;
    syncro_i       = 1'b0;
    if (n >= N) model_ch = (model_ch + 1) % CH_NUM;
    repeat (3) tick();
    chk("err_pulses", err_seen - e0, (n < N) ? 1 : 0);
    chk("overrun_pulses", ovr_seen - o0, trig_mid ? 1 : 0);
    chk("busy_after", busy_o, 0);
    chk("data_hold", int'(data_o), last_data);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 16; i++) smp[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) smp[i] = int'($urandom_range(0, 4095)) - 2048;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_req"}, adc_data_req_o, 0);
    chk({tag, "_ch"}, int'(adc_ch_o), 0);
    chk({tag, "_data"}, int'(data_o), 0);
    chk({tag, "_data_ch"}, int'(data_ch_o), 0);
    chk({tag, "_data_rdy"}, data_rdy_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_overrun"}, overrun_o, 0);
  endtask

  initial begin
    int e0;
    int k;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    reset_n_i = 1'b1;

    fill_const(100);
    burst(N, 1'b0);
    for (int i = 0; i < 16; i++) smp[i] = i + 1;
    burst(N, 1'b0);
    fill_const(-5);
    burst(N, 1'b0);
    fill_const(0);
    smp[0] = -1;
    burst(N, 1'b0);
    fill_rand();
    burst(N, 1'b0);

    // Aborted burst, then the same channel again.
    fill_rand();
    burst(5, 1'b0);
    fill_rand();
    burst(N, 1'b1);
    fill_const(2047);
    burst(N + 2, 1'b0);
    fill_const(-2048);
    burst(N, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int n;
      fill_rand();
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1))
                                      : int'($urandom_range(N, N + 2));
      burst(n, (n >= 4) && ($urandom_range(0, 1) == 1));
    end

    // No sample arrives after the request.
    tick();
    e0 = err_seen;
    trigger_to_wait();
`ifdef ADC_TIMEOUT_EN
    k = 0;
    while (err_seen == e0 && k < 40) begin
      tick();
      k++;
    end
    chk("timeout_err", err_seen - e0, 1);
    tick();
    chk("timeout_busy", busy_o, 0);
`else
    repeat (40) tick();
    chk("no_timeout_err", err_seen - e0, 0);
    chk("no_timeout_busy", busy_o, 1);
    fill_rand();
    push_expected();
    for (int i = 0; i < N; i++) begin
      adc_data_rdy_i = 1'b1;
      adc_data_i     = DATA_W'(smp[i]);
      tick();
    end
    adc_data_rdy_i = 1'b0;
    chk("late_burst_rdy", data_rdy_o, 1);
    model_ch = (model_ch + 1) % CH_NUM;
    tick();
`endif
    k = 0;

    // Reset asserted in the middle of a burst.
    fill_const(33);
    fill_rand();
    burst(N, 1'b0);
    tick();
    trigger_to_wait();
    for (int i = 0; i < 4; i++) begin
      adc_data_rdy_i = 1'b1;
      adc_data_i     = DATA_W'($urandom_range(0, 4095));
      tick();
    end
    chk("busy_before_reset", busy_o, 1);
    reset_n_i = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    reset_n_i = 1'b1;
    repeat (6) tick();
    adc_data_rdy_i = 1'b0;
    model_ch  = 0;
    last_data = 0;
    chk("post_reset_busy", busy_o, 0);

    fill_rand();
    burst(N, 1'b0);

    repeat (5) tick();
    chk("scoreboard_empty", exp_data.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

`default_nettype wire

// File: doc/adc_avg_mc.md
ADC_AVG_MC -- requirements
Module: adc_avg_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning the signed ADC sample width.
REQ-002 SHALL have parameter CH_NUM, default 4, meaning the number of ADC channels scanned round-robin (2..16).
REQ-003 SHALL have parameter AVG_LOG2, default 3, meaning log2 of the samples averaged per acquisition (0..6).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 32, meaning the maximum number of cycles from request to first adc_data_rdy_i.
REQ-005 SHALL have port clk_i  in  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n_i  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port syncro_i  in  1  acquisition trigger, sampled high on a rising edge.
REQ-008 SHALL have port adc_data_req_o  out  1  one-cycle conversion request to the ADC.
REQ-009 SHALL have port adc_ch_o  out  CH_W=$clog2(CH_NUM)  channel being requested, held through the acquisition.
REQ-010 SHALL have port adc_data_rdy_i  in  1  sample valid, one sample per high cycle.
REQ-011 SHALL have port adc_data_i  in  DATA_W  signed ADC sample.
REQ-012 SHALL have port data_o  out  DATA_W  signed averaged result.
REQ-013 SHALL have port data_ch_o  out  CH_W  channel of data_o.
REQ-014 SHALL have port data_rdy_o  out  1  one-cycle pulse, data_o/data_ch_o valid.
REQ-015 SHALL have ports err_o, overrun_o and busy_o  out  1 each  error pulse, dropped-trigger pulse, and acquisition in progress.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, ACQ, OUT.
REQ-017 In IDLE with syncro_i=1, SHALL go to REQ; REQ lasts exactly one cycle with adc_data_req_o=1, then goes to WAIT.
REQ-018 In WAIT, SHALL go to ACQ in the same cycle that adc_data_rdy_i=1, accepting that sample.
REQ-019 In WAIT/ACQ, SHALL accept adc_data_i on every cycle with adc_data_rdy_i=1 into a signed accumulator of DATA_W+AVG_LOG2 bits (no overflow possible).
REQ-020 After 2**AVG_LOG2 accepted samples, SHALL go to OUT and ignore further rdy cycles in this acquisition.
REQ-021 In OUT (one cycle), SHALL drive data_rdy_o=1, data_o=accumulator arithmetically shifted right by AVG_LOG2 (floor toward -inf), and data_ch_o=adc_ch_o; then advance the channel (CH_NUM-1 wraps to 0) and return to IDLE.
REQ-022 If adc_data_rdy_i falls in ACQ before the count is reached, SHALL pulse err_o, drop the result, keep the channel, and return to IDLE.
REQ-023 syncro_i=1 in any state other than IDLE SHALL pulse overrun_o the next cycle and SHALL NOT affect the acquisition in progress.
REQ-024 busy_o SHALL be 1 in every state other than IDLE.
REQ-025 data_o/data_ch_o SHALL hold their last value between data_rdy_o pulses.

Reset
REQ-026 Asserting reset_n_i low SHALL immediately force IDLE, channel 0, accumulator and counters 0, and every output 0, including mid-acquisition.
REQ-027 After reset release, the first syncro_i SHALL start an acquisition on channel 0.

Configuration
REQ-028 With ADC_TIMEOUT_EN defined, WAIT SHALL count cycles; on reaching TIMEOUT_CYC without rdy, SHALL pulse err_o, keep the channel, and return to IDLE.
REQ-029 Without ADC_TIMEOUT_EN, WAIT SHALL wait indefinitely and no timeout counter SHALL be synthesised.

Structure
REQ-030 Package adc_avg_pkg SHALL hold the FSM state enum and the CH_W/accumulator-width helper functions.
REQ-031 Sub-module adc_avg_acc SHALL hold the clear/accumulate/sample-count logic and the divide-by-shift.

Verification
REQ-032 8 samples of 100 on channel 0 -> data_o=100, data_ch_o=0, one data_rdy_o pulse the cycle after the 8th sample.
REQ-033 Samples 1..8 -> data_o=4; eight samples of -5 -> data_o=-5; samples -1,0x7 -> data_o=-1 (floor).
REQ-034 Five triggers with full bursts -> data_ch_o sequence 0,1,2,3,0.
REQ-035 rdy drops after 5 samples -> err_o pulse, no data_rdy_o, next acquisition reuses the same channel.
REQ-036 syncro_i pulsed during ACQ -> overrun_o pulse, result of the current burst unchanged; with ADC_TIMEOUT_EN and no rdy for 32 cycles -> err_o, busy_o returns to 0.
REQ-037 reset_n_i low during ACQ -> all outputs 0 within the same cycle, no data_rdy_o after release.
